// File: rtl/regs_mp_if.sv
// Register-file port bundle: two writeback ports, one issue port and NUM_RD read ports.
// The master (ID/WB side) drives writes, issue and read addresses; the slave (the register file) returns read results.
interface regs_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 6
);
   logic                     w0_e_i;
   logic [ADDR_W-1:0]        w0_addr_i;
   logic [DATA_W-1:0]        w0_data_i;
   logic                     w1_e_i;
   logic [ADDR_W-1:0]        w1_addr_i;
   logic [DATA_W-1:0]        w1_data_i;
   logic                     iss_e_i;
   logic [ADDR_W-1:0]        iss_addr_i;
   logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
   logic [NUM_RD*DATA_W-1:0] rd_data_o;
   logic [NUM_RD-1:0]        rd_busy_o;
   logic [CNT_W-1:0]         busy_cnt_o;

   modport master (
      output w0_e_i, w0_addr_i, w0_data_i, w1_e_i, w1_addr_i, w1_data_i,
             iss_e_i, iss_addr_i, rd_addr_i,
      input  rd_data_o, rd_busy_o, busy_cnt_o
   );

   modport slave (
      input  w0_e_i, w0_addr_i, w0_data_i, w1_e_i, w1_addr_i, w1_data_i,
             iss_e_i, iss_addr_i, rd_addr_i,
      output rd_data_o, rd_busy_o, busy_cnt_o
   );
endinterface

// File: rtl/regs_mp.sv
// Multi-port integer register file with dual prioritised writeback, same-cycle write bypass
// on every read port, and a per-register busy scoreboard with a registered population count.
module regs_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int CNT_W    = 6
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   regs_mp_if.slave   bus
);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]      busy_q, busy_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     w0_act, w1_act, iss_act;
   logic [ADDR_W-1:0]        ra;
   logic                     ra_wr;
   logic [NUM_RD*DATA_W-1:0] rd_data_d;
   logic [NUM_RD-1:0]        rd_busy_d;

   assign w0_act  = bus.w0_e_i  && (bus.w0_addr_i  != '0);
   assign w1_act  = bus.w1_e_i  && (bus.w1_addr_i  != '0);
   assign iss_act = bus.iss_e_i && (bus.iss_addr_i != '0);

   // Writes clear first, then issue sets, so a same-cycle issue keeps the new producer busy.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NUM_REGS; i++) begin
         if ((w0_act && bus.w0_addr_i == ADDR_W'(i)) || (w1_act && bus.w1_addr_i == ADDR_W'(i)))
            busy_d[i] = 1'b0;
         if (iss_act && bus.iss_addr_i == ADDR_W'(i))
            busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
      cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_d = cnt_d + CNT_W'(busy_d[i]);
   end

   // Port 1 is the younger instruction: its assignment comes last so it wins on a collision.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (w0_act) regs_q[bus.w0_addr_i] <= bus.w0_data_i;
         if (w1_act) regs_q[bus.w1_addr_i] <= bus.w1_data_i;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd_data_d = '0;
      rd_busy_d = '0;
      ra        = '0;
      ra_wr     = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra    = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
         ra_wr = (w0_act && bus.w0_addr_i == ra) || (w1_act && bus.w1_addr_i == ra);
         if (!rst && ra != '0) begin
            if (w1_act && bus.w1_addr_i == ra)
               rd_data_d[k*DATA_W +: DATA_W] = bus.w1_data_i;
            else if (w0_act && bus.w0_addr_i == ra)
               rd_data_d[k*DATA_W +: DATA_W] = bus.w0_data_i;
            else
               rd_data_d[k*DATA_W +: DATA_W] = regs_q[ra];
            rd_busy_d[k] = busy_q[ra] && !ra_wr;
         end
      end
   end

   assign bus.rd_data_o  = rd_data_d;
   assign bus.rd_busy_o  = rd_busy_d;
   assign bus.busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_regs_mp.sv
// Bench for regs_mp: directed scenarios plus random traffic, scored against an array-based reference model.
module tb_regs_mp;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NREGS = 32;
   localparam int NR    = 4;
   localparam int CW    = 6;
   localparam int EW    = NR*DW + NR + CW;

   logic clk_100MHz = 1'b0;
   logic rst        = 1'b1;

   regs_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) bus ();

   regs_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREGS), .NUM_RD(NR), .CNT_W(CW)) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .bus        (bus)
   );

   // clock / reset
   always #5 clk_100MHz = ~clk_100MHz;

   // reference model: architectural contents and busy flags
   logic [DW-1:0] m_mem  [NREGS];
   bit            m_busy [NREGS];

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [NR*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [AW-1:0] b0, b1, b2, b3;
      b0 = AW'(a0); b1 = AW'(a1); b2 = AW'(a2); b3 = AW'(a3);
      return {b3, b2, b1, b0};
   endfunction

   // driver: apply one cycle of inputs, push the expected outputs, advance the model over the edge
   task automatic cycle(input logic r,
                        input logic w0e, input int w0a, input logic [DW-1:0] w0d,
                        input logic w1e, input int w1a, input logic [DW-1:0] w1d,
                        input logic ie, input int ia, input logic [NR*AW-1:0] ra);
      logic [NR*DW-1:0] e_data;
      logic [NR-1:0]    e_busy;
      int               cnt;
      int               a;
      bit               wr;
      rst = r;
      bus.w0_e_i = w0e; bus.w0_addr_i = AW'(w0a); bus.w0_data_i = w0d;
      bus.w1_e_i = w1e; bus.w1_addr_i = AW'(w1a); bus.w1_data_i = w1d;
      bus.iss_e_i = ie; bus.iss_addr_i = AW'(ia);
      bus.rd_addr_i = ra;

      cnt = 0;
      for (int i = 0; i < NREGS; i++) cnt += int'(m_busy[i]);
      e_data = '0;
      e_busy = '0;
      for (int k = 0; k < NR; k++) begin
         a  = int'(ra[k*AW +: AW]);
         wr = (w0e && w0a == a) || (w1e && w1a == a);
         if (!r && a != 0) begin
            if (w1e && w1a == a)      e_data[k*DW +: DW] = w1d;
            else if (w0e && w0a == a) e_data[k*DW +: DW] = w0d;
            else                      e_data[k*DW +: DW] = m_mem[a];
            e_busy[k] = m_busy[a] && !wr;
         end
      end
      exp_q.push_back({e_data, e_busy, CW'(cnt)});

      if (r) begin
         for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      end else begin
         if (w0e && w0a != 0) begin m_mem[w0a] = w0d; m_busy[w0a] = 0; end
         if (w1e && w1a != 0) begin m_mem[w1a] = w1d; m_busy[w1a] = 0; end
         if (ie && ia != 0) m_busy[ia] = 1;
      end
      @(posedge clk_100MHz); #1;
   endtask

   task automatic idle_read(input logic [NR*AW-1:0] ra);
      cycle(0, 0, 0, '0, 0, 0, '0, 0, 0, ra);
   endtask

   function automatic int rnd_addr();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS-1)) : int'($urandom_range(0, 7));
   endfunction

   // monitor / scoreboard: outputs are sampled mid-cycle, away from the rising edge
   always @(negedge clk_100MHz) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.rd_data_o !== e[EW-1 -: NR*DW]) begin
            errors++;
            $display("FAIL rd_data t=%0t got %h exp %h", $time, bus.rd_data_o, e[EW-1 -: NR*DW]);
         end
         checks++;
         if (bus.rd_busy_o !== e[CW +: NR]) begin
            errors++;
            $display("FAIL rd_busy t=%0t got %b exp %b", $time, bus.rd_busy_o, e[CW +: NR]);
         end
         checks++;
         if (bus.busy_cnt_o !== e[CW-1:0]) begin
            errors++;
            $display("FAIL busy_cnt t=%0t got %0d exp %0d", $time, bus.busy_cnt_o, e[CW-1:0]);
         end
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      bus.w0_e_i = 0; bus.w0_addr_i = '0; bus.w0_data_i = '0;
      bus.w1_e_i = 0; bus.w1_addr_i = '0; bus.w1_data_i = '0;
      bus.iss_e_i = 0; bus.iss_addr_i = '0; bus.rd_addr_i = '0;
      rst = 1;
      repeat (2) @(posedge clk_100MHz);
      #1;

      // reset discards stored data
      cycle(0, 1, 5, 32'h1234, 0, 0, '0, 0, 0, pack4(5, 0, 0, 0));
      idle_read(pack4(5, 5, 0, 0));
      cycle(1, 1, 5, 32'h9999, 0, 0, '0, 1, 5, pack4(5, 5, 5, 5));
      idle_read(pack4(5, 5, 5, 5));

      // write/read and zero register
      cycle(0, 1, 3, 32'hDEADBEEF, 0, 0, '0, 0, 0, pack4(0, 0, 0, 0));
      idle_read(pack4(0, 3, 0, 0));
      cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, '0, 0, 0, pack4(0, 0, 0, 0));
      idle_read(pack4(0, 0, 3, 0));

      // dual write priority and bypass
      cycle(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, pack4(7, 0, 0, 0));
      idle_read(pack4(7, 0, 0, 0));

      // scoreboard set / clear
      cycle(0, 0, 0, '0, 0, 0, '0, 1, 9, pack4(9, 0, 0, 0));
      idle_read(pack4(9, 9, 0, 0));
      cycle(0, 0, 0, '0, 1, 9, 32'h55, 0, 0, pack4(9, 0, 0, 0));
      idle_read(pack4(9, 0, 0, 0));

      // issue/write collision keeps the bit set
      cycle(0, 0, 0, '0, 0, 0, '0, 1, 4, pack4(4, 0, 0, 0));
      cycle(0, 1, 4, 32'hAB, 0, 0, '0, 1, 4, pack4(4, 0, 0, 0));
      idle_read(pack4(4, 0, 0, 0));
      cycle(0, 0, 0, '0, 0, 0, '0, 1, 4, pack4(4, 0, 0, 0));
      idle_read(pack4(4, 0, 0, 0));

      // four ports at once
      cycle(0, 1, 1, 32'd1, 1, 2, 32'd2, 0, 0, pack4(0, 0, 0, 0));
      cycle(0, 1, 31, 32'd31, 0, 0, '0, 0, 0, pack4(0, 0, 0, 0));
      idle_read(pack4(1, 2, 0, 31));

      // random traffic, addresses biased low to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
               1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
               1'($urandom_range(0, 1)), rnd_addr(),
               pack4(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()));
      end

      @(negedge clk_100MHz); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
